// File: rtl/mul_pkg.sv
// Shared types, mode constants and operand-magnitude helper for the
// sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam logic MUL_SIGNED   = 1'b1;
  localparam logic MUL_UNSIGNED = 1'b0;

  // Caller passes the operand already sign- or zero-extended to 64 bits.
  // The most negative operand negates to exactly 2^(W-1), which still fits
  // W unsigned bits.
  function automatic logic [63:0] abs_w(input logic [63:0] value, input logic signed_mode);
    if (signed_mode == MUL_SIGNED && value[63]) begin
      return ~value + 64'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/mul_add_stage.sv
// WIDTH-bit adder with carry out, built as a carry-bypass adder.
// 4-bit blocks are used, and the last block may be partial.
module mul_add_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int BLK  = 4;
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
    assign prop[gi] = a_i[gi] ^ b_i[gi];
    assign gen[gi]  = a_i[gi] & b_i[gi];
  end

  // When every bit in a block propagates, the block carry-in skips the ripple.
  always_comb begin : adder
    logic carry;
    logic blk_cin;
    logic p_all;
    int   idx;
    sum_o   = '0;
    carry   = cin_i;
    blk_cin = 1'b0;
    p_all   = 1'b1;
    idx     = 0;
    for (int blk = 0; blk < NBLK; blk++) begin
      blk_cin = carry;
      p_all   = 1'b1;
      for (int k = 0; k < BLK; k++) begin
        idx = blk * BLK + k;
        if (idx < WIDTH) begin
          sum_o[idx] = prop[idx] ^ carry;
          carry      = gen[idx] | (prop[idx] & carry);
          p_all      = p_all & prop[idx];
        end
      end
      if (p_all) begin
        carry = blk_cin;
      end
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier. It retires one multiplier bit per clock.
// The sign is applied to the magnitude product in a single FIX cycle.
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  mul_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [63:0]        a_ext, b_ext;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  assign a_ext = (signed_mode == MUL_SIGNED) ? 64'(signed'(a)) : 64'(a);
  assign b_ext = (signed_mode == MUL_SIGNED) ? 64'(signed'(b)) : 64'(b);
  assign mag_a = WIDTH'(abs_w(a_ext, signed_mode));
  assign mag_b = WIDTH'(abs_w(b_ext, signed_mode));

  mul_add_stage #(.WIDTH(WIDTH)) u_add (
    .a_i    (acc_q[2*WIDTH-1:WIDTH]),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = mag_a;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d   = (signed_mode == MUL_SIGNED) & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        if (acc_q[0]) begin
          acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = acc_q >> 1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (neg_q) begin
          acc_d = (~acc_q) + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed checks of seq_shift_add_mul at WIDTH=32 and WIDTH=8.
// Covers products, latency, back-pressure and mid-calculation reset.
module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv32, ir32, sm32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_shift_add_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
  );

  seq_shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn32(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsm,
                          output logic [63:0] tp, output int lat);
    @(negedge clk);
    check("in_ready_before_txn32", 64'(ir32), 64'd1);
    a32 = ta; b32 = tb_v; sm32 = tsm; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0; a32 = '0; b32 = '0;
    lat = 1;
    while (!ov32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!ov32) begin
      tests++; fails++;
      $display("FAIL timeout32: out_valid never rose within %0d cycles", lat);
    end
    tp = p32;
  endtask

  task automatic release32();
    or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
  endtask

  task automatic do_txn8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                         output logic [15:0] tp, output int lat);
    @(negedge clk);
    check("in_ready_before_txn8", 64'(ir8), 64'd1);
    a8 = ta; b8 = tb_v; sm8 = tsm; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = '0; b8 = '0;
    lat = 1;
    while (!ov8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!ov8) begin
      tests++; fails++;
      $display("FAIL timeout8: out_valid never rose within %0d cycles", lat);
    end
    tp = p8;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    logic [63:0] p;
    logic [15:0] q;
    int          lat;
    logic        any_ov;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1]  = '{32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFFFFFFFFD6};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
    vecs[4]  = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
    vecs[5]  = '{32'h00000000, 32'h00012345, 1'b1, 64'h0000000000000000};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[7]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 64'h3FFFFFFF00000001};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE};
    vecs[10] = '{32'h00000005, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFF1};
    vecs[11] = '{32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780};

    iv32 = 0; a32 = '0; b32 = '0; sm32 = 0; or32 = 0;
    iv8 = 0; a8 = '0; b8 = '0; sm8 = 0; or8 = 0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(ir32), 64'd1);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_product", p32, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_txn32(vecs[i].a, vecs[i].b, vecs[i].sm, p, lat);
      check($sformatf("product32[%0d]", i), p, vecs[i].exp);
      check($sformatf("latency32[%0d]", i), 64'(lat), 64'd34);
      $display("[TB] vec %0d a=%h b=%h signed=%0d product=%h latency=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sm, p, lat);
      release32();
    end

    do_txn8(8'h00, 8'h80, 1'b1, q, lat);
    check("w8_zero_product", 64'(q), 64'h0000);
    check("w8_zero_latency", 64'(lat), 64'd10);
    $display("[TB] w8 0*0x80 signed product=%h latency=%0d", q, lat);
    do_txn8(8'h80, 8'h80, 1'b1, q, lat);
    check("w8_minmin_product", 64'(q), 64'h4000);
    $display("[TB] w8 0x80*0x80 signed product=%h", q);
    do_txn8(8'hFF, 8'hFF, 1'b0, q, lat);
    check("w8_ffff_product", 64'(q), 64'hFE01);
    $display("[TB] w8 0xFF*0xFF unsigned product=%h", q);

    // Back-pressure: hold the result while a second operand pair is offered.
    do_txn32(32'd6, 32'd7, 1'b0, p, lat);
    check("bp_product", p, 64'd42);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        a32 = 32'd9; b32 = 32'd9; iv32 = 1'b1;
      end
      if (c == 7) begin
        iv32 = 1'b0;
      end
      @(negedge clk);
      check("bp_hold_product", p32, 64'd42);
      check("bp_hold_in_ready", 64'(ir32), 64'd0);
      check("bp_hold_out_valid", 64'(ov32), 64'd1);
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
    check("bp_in_ready_after", 64'(ir32), 64'd1);
    check("bp_out_valid_after", 64'(ov32), 64'd0);
    @(negedge clk);
    check("bp_second_not_captured", 64'(busy32), 64'd0);
    $display("[TB] back-pressure done product=%h", p);

    // Reset in the middle of CALC.
    a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; sm32 = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (9) @(negedge clk);
    check("midcalc_busy_before_rst", 64'(busy32), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(ir32), 64'd1);
    check("midrst_out_valid", 64'(ov32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_product", p32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    any_ov = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ov32) any_ov = 1'b1;
    end
    check("no_out_valid_after_rst", 64'(any_ov), 64'd0);
    do_txn32(32'd3, 32'd5, 1'b0, p, lat);
    check("post_rst_product", p, 64'd15);
    check("post_rst_latency", 64'(lat), 64'd34);
    $display("[TB] post-reset 3*5 product=%h latency=%0d", p, lat);
    release32();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
